// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter sharing one registered 32-bit ALU.
// IDLE grants and latches, EXEC computes, RESP holds the result.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [3:0]  req_sel0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  input  logic [3:0]  req_sel1,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_zero,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        gnt_q, gnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] data_q, data_d;
  logic        zero_q, zero_d;
  logic        err_q, err_d;

  logic        gnt_c;
  logic [31:0] res_c;
  logic        ill_c;
  logic [4:0]  shamt;

  // Round-robin pick: on conflict the requester not served last wins
  always_comb begin
    if (req_valid[0] && req_valid[1]) begin
      gnt_c = ~last_q;
    end else begin
      gnt_c = ~req_valid[0];
    end
  end

  // ALU datapath on the latched operands
  always_comb begin
    res_c = '0;
    ill_c = 1'b0;
    shamt = b_q[4:0];
    case (sel_q)
      4'd0: res_c = a_q & b_q;
      4'd1: res_c = a_q | b_q;
      4'd2: res_c = a_q + b_q;
      4'd3: res_c = a_q - b_q;
      4'd4: res_c = a_q ^ b_q;
      4'd5: res_c = {31'd0, $signed(a_q) < $signed(b_q)};
      4'd7: res_c = a_q << shamt;
      4'd8: res_c = a_q >> shamt;
      4'd9: res_c = $unsigned($signed(a_q) >>> shamt);
      default: ill_c = 1'b1;
    endcase
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    a_d       = a_q;
    b_d       = b_q;
    sel_d     = sel_q;
    data_d    = data_q;
    zero_d    = zero_q;
    err_d     = err_q;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready = gnt_c ? 2'b10 : 2'b01;
          gnt_d     = gnt_c;
          last_d    = gnt_c;
          a_d       = gnt_c ? req_a1 : req_a0;
          b_d       = gnt_c ? req_b1 : req_b0;
          sel_d     = gnt_c ? req_sel1 : req_sel0;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        data_d  = res_c;
        zero_d  = (res_c == 32'd0);
        err_d   = ill_c;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = gnt_q ? 2'b10 : 2'b01;
        if (rsp_ready[gnt_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  assign rsp_data = data_q;
  assign rsp_zero = zero_q;
  assign rsp_err  = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random ops
// against a behavioural ALU and round-robin model.
module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] a0, b0, a1, b1;
  logic [3:0]  sel0, sel1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_zero;
  logic        rsp_err;

  int errors;
  int checks;
  int last_m;

  alu_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a0    (a0),
    .req_b0    (b0),
    .req_sel0  (sel0),
    .req_a1    (a1),
    .req_b1    (b1),
    .req_sel1  (sel1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural ALU
  task automatic ref_alu(input  logic [31:0] a,
                         input  logic [31:0] b,
                         input  logic [3:0]  sel,
                         output logic [31:0] res,
                         output logic        err);
    int sh;
    sh  = b % 32;
    res = 0;
    err = 0;
    case (sel)
      0: res = a & b;
      1: res = a | b;
      2: res = a + b;
      3: res = a - b;
      4: res = a ^ b;
      5: res = ($signed(a) < $signed(b)) ? 1 : 0;
      7: res = a << sh;
      8: res = a >> sh;
      9: res = $signed(a) >>> sh;
      default: err = 1;
    endcase
  endtask

  // One full transaction; hold = cycles the response is stalled
  task automatic run_op(input logic [1:0] vld, input int hold);
    int g;
    logic [31:0] er;
    logic        ee;
    logic [1:0]  oh;
    if (vld == 2'b11) g = 1 - last_m;
    else if (vld[0]) g = 0;
    else g = 1;
    if (g == 0) ref_alu(a0, b0, sel0, er, ee);
    else        ref_alu(a1, b1, sel1, er, ee);
    oh = (g == 0) ? 2'b01 : 2'b10;
    req_valid = vld;
    rsp_ready = (hold > 0) ? ~oh : 2'b11;
    @(negedge clk);
    chk("req_ready_grant", 32'(req_ready), 32'(oh));
    last_m = g;
    @(posedge clk); #1;
    @(negedge clk);
    chk("exec_rsp_valid", 32'(rsp_valid), 0);
    chk("exec_req_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'(oh));
    chk("rsp_data", rsp_data, er);
    chk("rsp_zero", 32'(rsp_zero), 32'(er == 0));
    chk("rsp_err", 32'(rsp_err), 32'(ee));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'(oh));
      chk("hold_rsp_data", rsp_data, er);
      chk("hold_req_ready", 32'(req_ready), 0);
    end
    rsp_ready = 2'b11;
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk("taken_rsp_valid", 32'(rsp_valid), 0);
    chk("retain_rsp_data", rsp_data, er);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    last_m    = 1;
    rst       = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    a0 = 0; b0 = 0; sel0 = 0;
    a1 = 0; b1 = 0; sel1 = 0;
    #2;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_zero", 32'(rsp_zero), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // ADD wraps to zero
    a0 = 32'hFFFF_FFFF; b0 = 1; sel0 = 2;
    run_op(2'b01, 0);

    // Conflict alternation
    a0 = 5; b0 = 7; sel0 = 3;
    a1 = 32'hFFFF_FFFF; b1 = 1; sel1 = 5;
    run_op(2'b11, 0);
    run_op(2'b11, 0);
    run_op(2'b11, 0);
    run_op(2'b11, 0);

    // Backpressure on requester 1
    a1 = 32'h8000_0000; b1 = 4; sel1 = 9;
    run_op(2'b10, 5);
    run_op(2'b11, 0);

    // Shift amount uses b[4:0]
    a0 = 1; b0 = 33; sel0 = 7;
    run_op(2'b01, 0);
    a0 = 32'h8000_0000; b0 = 31; sel0 = 8;
    run_op(2'b01, 0);

    // Undefined opcode, then a clean SLT
    a0 = 32'h1234; b0 = 5; sel0 = 6;
    run_op(2'b01, 0);
    a0 = 1; b0 = 2; sel0 = 5;
    run_op(2'b01, 0);

    // Reset while in RESP
    a0 = 3; b0 = 4; sel0 = 2;
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    @(negedge clk);
    chk("pre_rst_grant", 32'(req_ready), 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_rsp_valid", 32'(rsp_valid), 2'b01);
    chk("pre_rst_rsp_data", rsp_data, 7);
    rst = 1'b1;
    #1;
    chk("async_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("async_rst_rsp_data", rsp_data, 0);
    #2 rst = 1'b0;
    last_m = 1;
    @(posedge clk); #1;
    a0 = 9; b0 = 3; sel0 = 4;
    a1 = 9; b1 = 3; sel1 = 1;
    run_op(2'b11, 0);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      logic [1:0] v;
      a0   = $urandom;
      b0   = $urandom;
      sel0 = 4'($urandom_range(0, 15));
      a1   = $urandom;
      b1   = $urandom;
      sel1 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) b0 = 0;
      if ($urandom_range(0, 3) == 0) a1 = b1;
      v = 2'($urandom_range(1, 3));
      run_op(v, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter and sequencer that shares one 32-bit ALU datapath between two independent requesters. Each requester presents operands and a 4-bit opcode over a valid/ready handshake; the block grants one, latches the operands, computes the result in a registered execute stage, and returns the result, zero flag and error flag to the granted requester over a response valid/ready handshake. It sits between the instruction-issue logic of two clients and the shared ALU, and is the only path by which either client reaches the ALU.

## Interface
- No parameters; data width fixed at 32, requester count fixed at 2.
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  2  bit i: requester i presents an operation
- req_ready  output  2  bit i: requester i's operation accepted this cycle
- req_a0, req_b0  input  32 each  requester 0 operands
- req_sel0  input  4  requester 0 opcode
- req_a1, req_b1  input  32 each  requester 1 operands
- req_sel1  input  4  requester 1 opcode
- rsp_valid  output  2  bit i: response for requester i is valid
- rsp_ready  input  2  bit i: requester i takes its response
- rsp_data  output  32  result, shared by both response channels
- rsp_zero  output  1  rsp_data == 0
- rsp_err  output  1  opcode was undefined

## Operation
- Opcodes: 0 AND, 1 OR, 2 ADD (mod 2^32), 3 SUB (mod 2^32), 4 XOR, 5 SLT signed (result 1 or 0), 7 SLL by b[4:0], 8 SRL by b[4:0], 9 SRA by b[4:0] (sign fill). Codes 6, 10-15 undefined: result 0, rsp_zero=1, rsp_err=1.
- FSM states: IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: if any req_valid, grant per round-robin; req_ready[g]=1 combinationally for granted g only; latch a, b, sel, and grant index; go EXEC. req_ready is 0 in EXEC and RESP.
- Round-robin: register last_grant (reset value 1, so requester 0 wins first conflict). Both valid: grant ~last_grant. One valid: grant it. last_grant updates to g on every grant.
- EXEC: compute from latched operands, register rsp_data, rsp_zero, rsp_err; go RESP.
- RESP: rsp_valid[g]=1, other bit 0; rsp_data/zero/err held stable until rsp_ready[g]=1, then go IDLE. rsp_ready of the non-granted requester ignored.
- Requester operands/sel need only be stable in the handshake cycle.
- Reset mid-operation (EXEC or RESP): transaction dropped, no response issued, all state to reset values.

## Timing
- Reset values: req_ready=0 (IDLE with no valid), rsp_valid=2'b00, rsp_data=0, rsp_zero=0, rsp_err=0, last_grant=1, state IDLE.
- Request accepted at cycle T (req_valid[g]&req_ready[g]); rsp_valid[g] high from cycle T+2.
- Response taken at cycle R (rsp_valid[g]&rsp_ready[g]); rsp_valid drops at R+1; next request accepted no earlier than R+1.
- Max throughput: one operation per 3 cycles (rsp_ready held high).
- req_ready depends combinationally on req_valid; no other input-to-output combinational paths. rsp_* are registered.
- rsp_data/zero/err retain last values after response taken until next EXEC.

## Test plan
- Reset then single op: req0 ADD a=0xFFFFFFFF b=1 -> accepted T, rsp_valid=2'b01 at T+2, rsp_data=0, rsp_zero=1, rsp_err=0.
- Conflict: both valid continuously, rsp_ready=2'b11 -> grants alternate 0,1,0,1; req0 SUB 5-7 returns 0xFFFFFFFE, req1 SLT a=0xFFFFFFFF b=1 returns 1.
- Backpressure: req1 SRA a=0x80000000 b=4, rsp_ready[1]=0 for 5 cycles -> rsp_valid=2'b10 and rsp_data=0xF8000000 held stable; req_ready stays 0; accept after release.
- Shifts use b[4:0]: SLL a=1 b=33 -> 2; SRL a=0x80000000 b=31 -> 1.
- Undefined op: req0 sel=6 -> rsp_data=0, rsp_zero=1, rsp_err=1; SLT a=1 b=2 afterwards -> rsp_err=0.
- Reset asserted during RESP -> rsp_valid=0 and rsp_data=0 immediately (asynchronous); next conflict grants requester 0.
